// File: rtl/rob_retire_if.sv
// rob_retire_if: dispatch/complete/flush inputs and retire/status outputs of the reorder buffer
interface rob_retire_if #(
    parameter int TAG_W = 6,
    parameter int IDX_W = 5
);
    logic             dispatch_en;
    logic [TAG_W-1:0] dispatch_t;
    logic [TAG_W-1:0] dispatch_t_old;
    logic [IDX_W-1:0] dispatch_idx;
    logic             complete_en;
    logic [IDX_W-1:0] complete_idx;
    logic             flush;
    logic             rob_full;
    logic             rob_empty;
    logic             retire_en;
    logic [TAG_W-1:0] retire_t;
    logic [TAG_W-1:0] retire_t_old;

    modport master (
        output dispatch_en, dispatch_t, dispatch_t_old, complete_en, complete_idx, flush,
        input  dispatch_idx, rob_full, rob_empty, retire_en, retire_t, retire_t_old
    );

    modport slave (
        input  dispatch_en, dispatch_t, dispatch_t_old, complete_en, complete_idx, flush,
        output dispatch_idx, rob_full, rob_empty, retire_en, retire_t, retire_t_old
    );
endinterface

// File: rtl/rob_retire.sv
// rob_retire: in-order reorder buffer retiring completed head entries to the arch map
module rob_retire #(
    parameter int ROB_SZ = 32,
    parameter int TAG_W  = 6,
    parameter int IDX_W  = $clog2(ROB_SZ)
) (
    input logic         clock,
    input logic         reset,
    rob_retire_if.slave rob
);
    logic [ROB_SZ-1:0] valid_q, valid_d, done_q, done_d;
    logic [TAG_W-1:0]  t_q [ROB_SZ];
    logic [TAG_W-1:0]  t_old_q [ROB_SZ];
    logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;
    logic              full, accept, retire;

    assign full   = count_q == (IDX_W+1)'(ROB_SZ);
    assign accept = rob.dispatch_en & ~full;
    // gated by reset so the arch map never sees a retire in a reset cycle
    assign retire = reset & ~rob.flush & valid_q[head_q] & done_q[head_q];

    assign rob.rob_full     = full;
    assign rob.rob_empty    = count_q == '0;
    assign rob.dispatch_idx = tail_q;
    assign rob.retire_en    = retire;
    assign rob.retire_t     = retire ? t_q[head_q] : '0;
    assign rob.retire_t_old = retire ? t_old_q[head_q] : '0;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rob.flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (rob.complete_en && valid_q[rob.complete_idx]) done_d[rob.complete_idx] = 1'b1;
            if (retire) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + IDX_W'(1);
            end
            if (accept) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                tail_d          = tail_q + IDX_W'(1);
            end
            count_d = count_q + (IDX_W+1)'(accept) - (IDX_W+1)'(retire);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // payload is only observable through a valid entry, so it needs no reset
    always_ff @(posedge clock) begin
        if (accept) begin
            t_q[tail_q]     <= rob.dispatch_t;
            t_old_q[tail_q] <= rob.dispatch_t_old;
        end
    end
endmodule

// File: doc/rob_retire.md
ROB_RETIRE -- requirements
Module: rob_retire

Interface
REQ-001 Parameter ROB_SZ, default 32, number of reorder-buffer entries (power of two, >=4).
REQ-002 Parameter TAG_W, default 6, physical-register tag width (width of TAG).
REQ-003 Parameter IDX_W, default $clog2(ROB_SZ), entry index width.
REQ-004 Port clock  in  1  single clock; all state updates on rising edge.
REQ-005 Port reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-006 Port dispatch_en  in  1  dispatch request for one instruction this cycle.
REQ-007 Port dispatch_t  in  TAG_W  newly allocated physical tag T.
REQ-008 Port dispatch_t_old  in  TAG_W  previous mapping Told of the destination.
REQ-009 Port dispatch_idx  out  IDX_W  entry index the current dispatch is written to (tail pointer).
REQ-010 Port complete_en  in  1  completion broadcast valid.
REQ-011 Port complete_idx  in  IDX_W  entry index being marked complete.
REQ-012 Port flush  in  1  squash all entries (mispredict recovery).
REQ-013 Port rob_full  out  1  count == ROB_SZ.
REQ-014 Port rob_empty  out  1  count == 0.
REQ-015 Port retire_en  out  1  head entry retires this cycle; drives arch_map retire_en.
REQ-016 Port retire_t  out  TAG_W  T of retiring entry; drives arch_map retire_t.
REQ-017 Port retire_t_old  out  TAG_W  Told of retiring entry; drives arch_map retire_t_old and free-list return.

Function
REQ-018 State: per-entry {valid, done, t, t_old}; head and tail pointers (IDX_W bits); count (IDX_W+1 bits).
REQ-019 Dispatch is accepted when dispatch_en=1 and rob_full=0 at the start of the cycle; the entry at tail gets valid=1, done=0, t, t_old; tail increments by 1 mod ROB_SZ; count increments.
REQ-020 Dispatch while rob_full=1 is ignored: no state change, no error; upstream is required to stall on rob_full.
REQ-021 Dispatch during a cycle in which the head retires while full is still ignored (full is evaluated from registered count, no same-cycle bypass).
REQ-022 complete_en=1 sets done=1 on entry complete_idx at the next edge only if that entry is valid; completion to an invalid entry is ignored.
REQ-023 retire_en is combinational: 1 iff entry[head].valid=1 and entry[head].done=1 and flush=0.
REQ-024 retire_t and retire_t_old are combinational from entry[head]; they are 0 whenever retire_en=0.
REQ-025 When retire_en=1, at the next edge entry[head].valid clears, head increments mod ROB_SZ, count decrements.
REQ-026 At most one retire and one dispatch per cycle; simultaneous dispatch and retire leave count unchanged and advance both pointers.
REQ-027 A completion of the head entry in cycle N produces retire_en=1 in cycle N+1 (one-cycle minimum complete-to-retire latency).
REQ-028 Pointers wrap from ROB_SZ-1 to 0 with no bubble.
REQ-029 flush=1 has priority over dispatch, complete and retire: at the next edge all valid/done clear, head=tail=0, count=0; retire_en=0 during the flush cycle.
REQ-030 rob_full and rob_empty are decoded from registered count only.

Reset
REQ-031 When reset=0 at a rising edge: all valid/done=0, head=tail=0, count=0; dispatch, complete and flush inputs ignored that cycle.
REQ-032 Values after reset: retire_en=0, retire_t=0, retire_t_old=0, rob_full=0, rob_empty=1, dispatch_idx=0.
REQ-033 Reset asserted mid-operation discards all in-flight entries; no retire occurs in the reset cycle or the cycle after.

Verification
REQ-034 Reset, then dispatch T=33/Told=5 -> dispatch_idx=0, rob_empty=0 next cycle; retire_en=0 until complete_idx=0; retire_en=1, retire_t=33, retire_t_old=5 the cycle after completion.
REQ-035 Dispatch 3 entries, complete idx 2 then 1 then 0 -> no retire until idx 0 is done; then retire_en=1 for 3 consecutive cycles, in program order 0,1,2.
REQ-036 Fill 32 entries -> rob_full=1; 33rd dispatch_en ignored (dispatch_idx stays 0, count 32); retire head and dispatch next cycle -> accepted at idx 0.
REQ-037 Run 40 dispatch/complete/retire cycles with head and tail crossing 31->0 -> retire order and tags match a reference queue, no lost or duplicated entries.
REQ-038 With 5 entries, head done, assert flush -> retire_en=0 that cycle; next cycle rob_empty=1, dispatch_idx=0; complete_en to an old idx has no effect.
REQ-039 Drive reset=0 with a retirable head -> retire_en=0 on the following cycle, all outputs at REQ-032 values.
